// File: rtl/sr_ff_bank_pkg.sv
// Shared definitions for the SR flip-flop bank: S=R=1 resolution modes,
// the per-bit next-state function and a popcount helper for reset values.
package sr_pkg;

    localparam int SR_SET_DOM = 0;
    localparam int SR_RST_DOM = 1;
    localparam int SR_TOGGLE  = 2;
    localparam int SR_HOLD    = 3;

    typedef logic [1:0] sr_mode_t;

    function automatic logic sr_next(input logic q, input logic s, input logic r, input int mode);
        logic n;
        n = q;
        case ({s, r})
            2'b10:   n = 1'b1;
            2'b01:   n = 1'b0;
            2'b11: begin
                case (mode)
                    SR_SET_DOM: n = 1'b1;
                    SR_RST_DOM: n = 1'b0;
                    SR_TOGGLE:  n = ~q;
                    default:    n = q;
                endcase
            end
            default: n = q;
        endcase
        return n;
    endfunction

    function automatic int popcount32(input logic [31:0] v);
        int c;
        c = 0;
        for (int i = 0; i < 32; i++) begin
            c = c + int'(v[i]);
        end
        return c;
    endfunction

endpackage

// File: rtl/sr_ff_bank_if.sv
// Control and status bundle of the SR flip-flop bank; the bank sits on the
// slave side, whoever drives S/R/en uses the master side.
interface sr_ff_bank_if #(parameter int WIDTH = 8);

    localparam int CW = $clog2(WIDTH + 1);
    localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    logic             en;
    logic [WIDTH-1:0] S;
    logic [WIDTH-1:0] R;
    logic [WIDTH-1:0] Q;
    logic [CW-1:0]    count;
    logic             changed;
    logic             first_valid;
    logic [IW-1:0]    first_idx;

    modport master (
        output en, S, R,
        input  Q, count, changed, first_valid, first_idx
    );

    modport slave (
        input  en, S, R,
        output Q, count, changed, first_valid, first_idx
    );

endinterface

// File: rtl/sr_ff_bank_cell.sv
// One SR channel: optional rising-edge qualifier on S, next-state resolution
// and the Q flop. q_next is exported so the bank can derive status from it.
module sr_cell
    import sr_pkg::*;
#(
    parameter int   MODE     = SR_SET_DOM,
    parameter int   EDGE     = 0,
    parameter logic INIT_BIT = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    input  logic s,
    input  logic r,
    output logic q,
    output logic q_next
);

    logic q_q, q_d;
    logic s_prev_q, s_prev_d;
    logic s_eff;

    // s_prev tracks S even while disabled, so edges seen during en=0 are lost
    always_comb begin
        s_prev_d = s;
        s_eff    = (EDGE != 0) ? (s & ~s_prev_q) : s;
        q_d      = en ? sr_next(q_q, s_eff, r, MODE) : q_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q_q      <= INIT_BIT;
            s_prev_q <= 1'b0;
        end else begin
            q_q      <= q_d;
            s_prev_q <= s_prev_d;
        end
    end

    assign q      = q_q;
    assign q_next = q_d;

endmodule

// File: rtl/sr_ff_bank.sv
// Bank of WIDTH sticky SR flags with registered popcount, change pulse and
// capture of the lowest channel that set first since the bank was all-zero.
module sr_ff_bank
    import sr_pkg::*;
#(
    parameter int          WIDTH = 8,
    parameter int          MODE  = SR_SET_DOM,
    parameter int          EDGE  = 0,
    parameter logic [31:0] INIT  = 32'd0
) (
    input  logic          clk,
    input  logic          reset,
    sr_ff_bank_if.slave   bus
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] INIT_COUNT = CW'(popcount32(INIT));

    if (WIDTH < 1 || WIDTH > 32) begin : g_bad_width
        $error("sr_ff_bank: WIDTH must be 1..32");
    end
    if (MODE < SR_SET_DOM || MODE > SR_HOLD) begin : g_bad_mode
        $error("sr_ff_bank: MODE must be 0..3");
    end
    if (EDGE != 0 && EDGE != 1) begin : g_bad_edge
        $error("sr_ff_bank: EDGE must be 0 or 1");
    end
    if (WIDTH < 32 && (INIT >> WIDTH) != 32'd0) begin : g_bad_init
        $error("sr_ff_bank: INIT wider than WIDTH");
    end

    logic [WIDTH-1:0] q_vec;
    logic [WIDTH-1:0] q_next;

    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        sr_cell #(
            .MODE     (MODE),
            .EDGE     (EDGE),
            .INIT_BIT (INIT[i])
        ) u_cell (
            .clk    (clk),
            .reset  (reset),
            .en     (bus.en),
            .s      (bus.S[i]),
            .r      (bus.R[i]),
            .q      (q_vec[i]),
            .q_next (q_next[i])
        );
    end

    logic [CW-1:0]    count_q, count_d;
    logic             changed_q, changed_d;
    logic             first_valid_q, first_valid_d;
    logic [IW-1:0]    first_idx_q, first_idx_d;
    logic [WIDTH-1:0] rise;
    logic [IW-1:0]    low_idx;

    always_comb begin
        count_d = '0;
        for (int i = 0; i < WIDTH; i++) begin
            count_d = count_d + CW'(q_next[i]);
        end

        changed_d = |(q_next ^ q_vec);
        rise      = q_next & ~q_vec;

        low_idx = '0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (rise[i]) begin
                low_idx = IW'(i);
            end
        end

        // Going all-zero re-arms capture and wins over a same-edge capture
        first_valid_d = first_valid_q;
        first_idx_d   = first_idx_q;
        if (bus.en) begin
            if (q_next == '0) begin
                first_valid_d = 1'b0;
            end else if (!first_valid_q && (|rise)) begin
                first_valid_d = 1'b1;
                first_idx_d   = low_idx;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q       <= INIT_COUNT;
            changed_q     <= 1'b0;
            first_valid_q <= 1'b0;
            first_idx_q   <= '0;
        end else begin
            count_q       <= count_d;
            changed_q     <= changed_d;
            first_valid_q <= first_valid_d;
            first_idx_q   <= first_idx_d;
        end
    end

    assign bus.Q           = q_vec;
    assign bus.count       = count_q;
    assign bus.changed     = changed_q;
    assign bus.first_valid = first_valid_q;
    assign bus.first_idx   = first_idx_q;

endmodule
